// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with an output FIFO.
//   Frame format: 1 start bit, DATA_BITS data bits (LSB first), an optional
//   odd/even parity bit, and STOP_BITS stop bits. Start detection needs the
//   line to stay low up to the start-bit midpoint, so short low pulses are
//   ignored. A stop bit sampled low is reported as a framing error. If the
//   line is still low after the last stop sample, the receiver treats it as a
//   break and waits for the line to return high before looking for a new start.
// Ports:
//   clk_in, rst          clock, synchronous active-high reset
//   rx_en                oversample tick (OVERSAMPLE ticks per bit)
//   rx_serial_data       asynchronous serial line, idle high
//   rx_data, rx_parity_err, rx_frame_err   FIFO head entry
//   rx_valid / rx_ready  head handshake; an entry is popped when both are high
//   rx_overrun           1-cycle pulse when a completed frame is dropped (FIFO full)
//   rx_busy              receiver FSM not idle
//   fifo_count           number of occupied FIFO entries
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic                          rx_serial_data,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = DATA_BITS + 2;

  localparam logic [CW-1:0]   HALF      = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0]   LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic            LAST_STOP = (STOP_BITS == 2);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  // ---------------- input synchroniser (advances on ticks only)
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;

  always_ff @(posedge clk_in) begin
    if (rst)        sync_q <= '1;
    else if (rx_en) sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial_data};
  end
  assign rx_sync = sync_q[SYNC_STAGES-1];

  // ---------------- receive FSM
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic                   stop_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   par_err_now;

  always_comb begin
    par_err_now = 1'b0;
    if (PARITY == 1)      par_err_now = ~(^shreg_q ^ rx_sync);
    else if (PARITY == 2) par_err_now = ^shreg_q ^ rx_sync;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (rx_en) begin
      case (state_q)
        IDLE: if (!rx_sync) begin
          state_q <= START;
          cnt_q   <= '0;
          bit_q   <= '0;
          stop_q  <= 1'b0;
          perr_q  <= 1'b0;
          ferr_q  <= 1'b0;
        end
        // line must stay low up to the start-bit midpoint
        START: if (rx_sync) begin
          state_q <= IDLE;
        end else if (cnt_q == HALF) begin
          cnt_q   <= '0;
          state_q <= DATA;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
        end
        DATA: if (cnt_q == LAST_TICK) begin
          cnt_q   <= '0;
          shreg_q <= {rx_sync, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_q   <= '0;
            state_q <= (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_q   <= bit_q + 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        PAR: if (cnt_q == LAST_TICK) begin
          cnt_q   <= '0;
          perr_q  <= par_err_now;
          state_q <= STOP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        STOP: if (cnt_q == LAST_TICK) begin
          cnt_q <= '0;
          if (!rx_sync) ferr_q <= 1'b1;
          if (stop_q == LAST_STOP) begin
            stop_q  <= 1'b0;
            state_q <= rx_sync ? IDLE : BRK;
          end else begin
            stop_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        BRK: if (rx_sync) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state_q != IDLE);

  // Frame is complete on the last stop sample; the current sample still
  // contributes to the framing error of the pushed word.
  logic          push;
  logic [EW-1:0] push_word;
  assign push      = rx_en && (state_q == STOP) && (cnt_q == LAST_TICK) && (stop_q == LAST_STOP);
  assign push_word = {ferr_q | ~rx_sync, perr_q, shreg_q};

  // ---------------- output FIFO
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            overrun_q;
  logic            full, pop, wr;

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && rx_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr   = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (wr) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign {rx_frame_err, rx_parity_err, rx_data} = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != '0);
  assign rx_overrun = overrun_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  logic clk = 1'b0, rst = 1'b1, rx_en = 1'b0;
  logic ser0 = 1'b1, ser1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;

  logic [7:0] d0, d1;
  logic pe0, pe1, fe0, fe1, v0, v1, ov0, ov1, busy0, busy1;
  logic [2:0] cnt0, cnt1;

  typedef struct packed { logic ferr; logic perr; logic [7:0] data; } exp_t;
  exp_t q0[$], q1[$];
  int tests = 0, fails = 0, ovr0 = 0;

  uart_rx_param u_dut0 (
    .clk_in(clk), .rst(rst), .rx_en(rx_en), .rx_serial_data(ser0),
    .rx_data(d0), .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_valid(v0),
    .rx_ready(rdy0), .rx_overrun(ov0), .rx_busy(busy0), .fifo_count(cnt0));

  uart_rx_param #(.PARITY(2)) u_dut1 (
    .clk_in(clk), .rst(rst), .rx_en(rx_en), .rx_serial_data(ser1),
    .rx_data(d1), .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_valid(v1),
    .rx_ready(rdy1), .rx_overrun(ov1), .rx_busy(busy1), .fifo_count(cnt1));

  always #5 clk = ~clk;

  // oversample tick every other clock
  initial forever begin
    @(posedge clk);
    #1 rx_en = ~rx_en;
  end

  // monitor: pops the scoreboard whenever a DUT hands over an entry
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (v0 && rdy0) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL dut0_unexpected: got data=%h perr=%b ferr=%b, required no entry", d0, pe0, fe0);
        end else begin
          e = q0.pop_front();
          if ({fe0, pe0, d0} !== e) begin
            fails++;
            $display("FAIL dut0_entry: got ferr=%b perr=%b data=%h, required ferr=%b perr=%b data=%h",
                     fe0, pe0, d0, e.ferr, e.perr, e.data);
          end
        end
      end
      if (v1 && rdy1) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL dut1_unexpected: got data=%h perr=%b ferr=%b, required no entry", d1, pe1, fe1);
        end else begin
          e = q1.pop_front();
          if ({fe1, pe1, d1} !== e) begin
            fails++;
            $display("FAIL dut1_entry: got ferr=%b perr=%b data=%h, required ferr=%b perr=%b data=%h",
                     fe1, pe1, d1, e.ferr, e.perr, e.data);
          end
        end
      end
      if (ov0) ovr0++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // returns just after an edge on which the DUT consumed a tick
  task automatic tick();
    do @(posedge clk); while (rx_en !== 1'b1);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) ser0 = v; else ser1 = v;
  endtask

  task automatic send_bit(input int w, input logic v);
    set_line(w, v);
    ticks(16);
  endtask

  // start + data (+ parity when par >= 0)
  task automatic send_head(input int w, input logic [7:0] d, input int par);
    send_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(w, d[i]);
    if (par >= 0) send_bit(w, par[0]);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input int par);
    send_head(w, d, par);
    send_bit(w, 1'b1);
    set_line(w, 1'b1);
    ticks(32);
  endtask

  task automatic wait_drain(input int w, input string name);
    int n = 0;
    while (((w == 0) ? q0.size() : q1.size()) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #2;
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s: got %0d entries outstanding, required 0", name,
               (w == 0) ? q0.size() : q1.size());
    end
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #2;
    chk("reset_data",   d0,    0);
    chk("reset_valid",  v0,    0);
    chk("reset_errs",   {fe0, pe0}, 0);
    chk("reset_ovr",    ov0,   0);
    chk("reset_busy",   busy0, 0);
    chk("reset_count",  cnt0,  0);
    rst = 1'b0;
    ticks(8);

    // 1: plain frame
    q0.push_back('{1'b0, 1'b0, 8'hA5});
    send_frame(0, 8'hA5, -1);
    wait_drain(0, "t1_drain");

    // 2: even parity, wrong then right parity bit
    q1.push_back('{1'b0, 1'b1, 8'h03});
    send_frame(1, 8'h03, 1);
    wait_drain(1, "t2_bad_par_drain");
    q1.push_back('{1'b0, 1'b0, 8'h03});
    send_frame(1, 8'h03, 0);
    wait_drain(1, "t2_good_par_drain");

    // 3: stop held low three bit periods -> framing error + break
    q0.push_back('{1'b1, 1'b0, 8'h0F});
    send_head(0, 8'h0F, -1);
    set_line(0, 1'b0);
    ticks(40);
    chk("t3_break_busy", busy0, 1);
    ticks(8);
    set_line(0, 1'b1);
    ticks(32);
    chk("t3_break_exit", busy0, 0);
    wait_drain(0, "t3_ferr_drain");
    q0.push_back('{1'b0, 1'b0, 8'h55});
    send_frame(0, 8'h55, -1);
    wait_drain(0, "t3_next_drain");

    // 4: 5-tick low glitch
    set_line(0, 1'b0);
    ticks(5);
    set_line(0, 1'b1);
    chk("t4_busy_seen", busy0, 1);
    ticks(32);
    chk("t4_busy_clear", busy0, 0);
    chk("t4_count", cnt0, 0);

    // 5: overrun with consumer stalled
    rdy0 = 1'b0;
    ovr0 = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q0.push_back('{1'b0, 1'b0, 8'(i)});
      send_frame(0, 8'(i), -1);
    end
    chk("t5_count_full", cnt0, 4);
    chk("t5_overruns", ovr0, 1);
    rdy0 = 1'b1;
    wait_drain(0, "t5_drain");
    chk("t5_count_empty", cnt0, 0);

    // 6: reset in the middle of data bit 3
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    set_line(0, 1'b0);
    ticks(8);
    rst = 1'b1;
    set_line(0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_count", cnt0, 0);
    rst = 1'b0;
    ticks(32);
    chk("t6_no_partial", v0, 0);
    q0.push_back('{1'b0, 1'b0, 8'h3C});
    send_frame(0, 8'h3C, -1);
    wait_drain(0, "t6_drain");

    ticks(8);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
